// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared constants for the I2S audio transmit path: default
//                fractional-divider settings (12.288 MHz MCLK from 74.25 MHz)
//                and I2S frame geometry (two 32-bit slots per frame).
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Default accumulator settings: MCLK toggle rate = clock * INC / MOD.
    localparam int unsigned ACCUM_INC_DEFAULT = 245760;
    localparam int unsigned ACCUM_MOD_DEFAULT = 742500;

    // I2S frame geometry.
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    // Index widths derived from the frame geometry.
    localparam int SLOT_IDX_W = $clog2(SLOT_BITS);
    localparam int CNT_W      = $clog2(FRAME_BITS);

endpackage
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sample_fifo
//  Description : Small synchronous FIFO holding stereo sample pairs, with
//                full/empty flags. Pushes while full and pops while empty are
//                ignored. Reset empties the FIFO (contents discarded).
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clock      in   system clock
//    reset      in   synchronous, active-high
//    push       in   write push_data this cycle
//    push_data  in   WIDTH-bit entry
//    pop        in   retire the head entry this cycle
//    pop_data   out  head entry (valid while !empty)
//    full       out  DEPTH entries held
//    empty      out  no entries held
// ============================================================================
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4    // power of two, >= 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == (c_aw+1)'(DEPTH));
    assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : I2S audio transmitter. A fractional accumulator derives
//                MCLK from the system clock; SCLK is MCLK/4 and LRCK is
//                SCLK/64. Sample pairs enter through a valid/ready handshake
//                and are shifted out MSB-first with the standard one-bit I2S
//                delay. All audio clocks are registered data outputs.
//  Revision    : 1.0 - initial release
//
//  Build option:
//    AUDIO_I2S_TX_FIFO_EN  defined  : FIFO of FIFO_DEPTH sample pairs
//                          undefined: single holding register (depth 1)
//
//  Ports:
//    clock         in   system clock
//    reset         in   synchronous, active-high
//    sample_valid  in   sample pair offered
//    sample_ready  out  can accept (transfer on valid && ready)
//    sample_left   in   left PCM sample, two's complement
//    sample_right  in   right PCM sample (ignored when MONO=1)
//    audio_mclk    out  master clock
//    audio_lrck    out  word select, 0 = left
//    audio_dac     out  serial data
//    frame_start   out  one-cycle pulse at each pop point
//    underflow     out  one-cycle pulse when a frame starts empty
// ============================================================================
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned ACCUM_INC    = ACCUM_INC_DEFAULT,
    parameter int unsigned ACCUM_MOD    = ACCUM_MOD_DEFAULT,
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter bit          MONO         = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    audio_mclk,
    output logic                    audio_lrck,
    output logic                    audio_dac,
    output logic                    frame_start,
    output logic                    underflow
);

    localparam int                 c_acc_w = $clog2(ACCUM_MOD + ACCUM_INC);
    localparam logic [c_acc_w-1:0] c_inc   = c_acc_w'(ACCUM_INC);
    localparam logic [c_acc_w-1:0] c_mod   = c_acc_w'(ACCUM_MOD);

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] left;
        logic [SAMPLE_WIDTH-1:0] right;
    } pair_t;

    logic [c_acc_w-1:0]      r_acc;
    logic                    r_mclk;
    logic [1:0]              r_div;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_lrck;
    logic                    r_dac;
    logic                    r_frame_start;
    logic                    r_underflow;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_hold_r;

    logic                    w_mclk_toggle;
    logic                    w_mclk_rise;
    logic                    w_sclk_fall;
    logic                    w_frame_start;
    logic [CNT_W-1:0]        w_cnt_next;
    pair_t                   w_push_pair;
    pair_t                   w_pop_pair;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;

    // ------------------------------------------------------------------
    // Clock generation. SCLK is never materialised: its falling edge is
    // the MCLK rise on which the 2-bit divider wraps 3 -> 0.
    // ------------------------------------------------------------------
    assign w_mclk_toggle = (r_acc >= c_mod);
    assign w_mclk_rise   = w_mclk_toggle && !r_mclk;
    assign w_sclk_fall   = w_mclk_rise && (r_div == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= '0;
            r_mclk <= 1'b0;
            r_div  <= 2'd0;
        end else if (w_mclk_toggle) begin
            r_acc  <= r_acc - c_mod + c_inc;
            r_mclk <= ~r_mclk;
            if (!r_mclk) r_div <= r_div + 2'd1;
        end else begin
            r_acc  <= r_acc + c_inc;
        end
    end

    // ------------------------------------------------------------------
    // Sample intake. In mono the left sample is duplicated at the input
    // so the right slot needs no special casing downstream.
    // ------------------------------------------------------------------
    always_comb begin
        w_push_pair       = '0;
        w_push_pair.left  = sample_left;
        w_push_pair.right = MONO ? sample_left : sample_right;
    end

    assign sample_ready  = !w_full && !reset;
    assign w_push        = sample_valid && sample_ready;
    assign w_frame_start = w_sclk_fall && (r_cnt == CNT_W'(FRAME_BITS - 1));
    assign w_pop         = w_frame_start && !w_empty;

`ifdef AUDIO_I2S_TX_FIFO_EN
    audio_sample_fifo #(
        .WIDTH ($bits(pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_pair),
        .pop       (w_pop),
        .pop_data  (w_pop_pair),
        .full      (w_full),
        .empty     (w_empty)
    );
`else
    pair_t r_hold_pair;
    logic  r_hold_full;

    // Push and pop never coincide here: push needs !full, pop needs full.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_pair <= '0;
            r_hold_full <= 1'b0;
        end else if (w_push) begin
            r_hold_pair <= w_push_pair;
            r_hold_full <= 1'b1;
        end else if (w_pop) begin
            r_hold_full <= 1'b0;
        end
    end

    assign w_pop_pair = r_hold_pair;
    assign w_full     = r_hold_full;
    assign w_empty    = !r_hold_full;
`endif

    // ------------------------------------------------------------------
    // Serializer. Slot bit 0 is the I2S delay bit; the shift register is
    // loaded there and zero-fills, so bits past SAMPLE_WIDTH come out 0.
    // ------------------------------------------------------------------
    assign w_cnt_next = r_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= '0;
            r_lrck        <= 1'b0;
            r_dac         <= 1'b0;
            r_shift       <= '0;
            r_hold_r      <= '0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            if (w_sclk_fall) begin
                r_cnt  <= w_cnt_next;
                r_lrck <= w_cnt_next[CNT_W-1];
                if (w_cnt_next[SLOT_IDX_W-1:0] == '0) begin
                    r_dac <= 1'b0;
                    if (w_frame_start) begin
                        r_frame_start <= 1'b1;
                        if (!w_empty) begin
                            r_shift  <= w_pop_pair.left;
                            r_hold_r <= w_pop_pair.right;
                        end else begin
                            // Play silence rather than repeating stale data.
                            r_shift     <= '0;
                            r_hold_r    <= '0;
                            r_underflow <= 1'b1;
                        end
                    end else begin
                        r_shift <= r_hold_r;
                    end
                end else begin
                    r_dac   <= r_shift[SAMPLE_WIDTH-1];
                    r_shift <= r_shift << 1;
                end
            end
        end
    end

    assign audio_mclk  = r_mclk;
    assign audio_lrck  = r_lrck;
    assign audio_dac   = r_dac;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_audio_i2s_tx
//  Description : Self-checking bench for audio_i2s_tx. A stereo and a mono
//                instance share all stimulus. The reference model tracks the
//                sample queue, frame position and expected serial bits from
//                the I2S framing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

    localparam int    W   = 16;
    localparam longint INC = 245760;
    localparam longint MOD = 742500;
`ifdef AUDIO_I2S_TX_FIFO_EN
    localparam int    DEPTH = 4;
`else
    localparam int    DEPTH = 1;
`endif

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_s;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         sample_valid = 1'b0;
    logic [W-1:0] sample_left  = '0;
    logic [W-1:0] sample_right = '0;
    logic         sample_ready, audio_mclk, audio_lrck, audio_dac, frame_start, underflow;
    logic         m_ready, m_mclk, m_lrck, m_dac, m_frame_start, m_underflow;

    always #5 clock = ~clock;

    audio_i2s_tx #(.SAMPLE_WIDTH(W), .FIFO_DEPTH(4), .MONO(1'b0)) dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_left(sample_left),
        .sample_right(sample_right), .audio_mclk(audio_mclk),
        .audio_lrck(audio_lrck), .audio_dac(audio_dac),
        .frame_start(frame_start), .underflow(underflow)
    );

    audio_i2s_tx #(.SAMPLE_WIDTH(W), .FIFO_DEPTH(4), .MONO(1'b1)) dut_m (
        .clock(clock), .reset(reset), .sample_valid(sample_valid),
        .sample_ready(m_ready), .sample_left(sample_left),
        .sample_right(sample_right), .audio_mclk(m_mclk),
        .audio_lrck(m_lrck), .audio_dac(m_dac),
        .frame_start(m_frame_start), .underflow(m_underflow)
    );

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;

    // Reference model state
    pair_s  q[$];        // samples accepted but not yet played
    pair_s  pend[$];     // stimulus waiting to be offered
    pair_s  cur = '0;    // pair playing in the current frame
    bit     offer = 1'b0;
    longint rises = 0;   // MCLK rising edges since reset
    longint events = 0;  // SCLK falling edges since reset
    int     rel_cyc = 0;
    logic   prev_mclk = 1'b0, prev_lrck = 1'b0;
    logic   exp_lrck = 1'b0, exp_dac = 1'b0, exp_dac_m = 1'b0;
    int     lrck_last = -1;
    int     uf_seen = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Serial bit at slot position p: bit 0 is the delay bit, then MSB-first.
    function automatic logic slot_bit(input logic [W-1:0] s, input int p);
        if (p >= 1 && p <= W) return s[W-p];
        return 1'b0;
    endfunction

    task automatic drive();
        sample_valid = offer && (pend.size() > 0);
        if (pend.size() > 0) begin
            sample_left  = pend[0].l;
            sample_right = pend[0].r;
        end
    endtask

    task automatic tick();
        logic  push_ok;
        pair_s head;
        logic  fs_e, uf_e;
        int    pos;
        drive();
        push_ok = sample_valid && !reset && (q.size() < DEPTH);
        head.l  = sample_left;
        head.r  = sample_right;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (underflow) uf_seen++;
        if (reset) begin
            q.delete();
            rises = 0; events = 0; cur = '0; rel_cyc = 0;
            exp_lrck = 0; exp_dac = 0; exp_dac_m = 0;
            prev_mclk = 0; prev_lrck = 0; lrck_last = -1;
            check_eq("rst_mclk", audio_mclk, 0);
            check_eq("rst_lrck", audio_lrck, 0);
            check_eq("rst_dac", audio_dac, 0);
            check_eq("rst_frame_start", frame_start, 0);
            check_eq("rst_underflow", underflow, 0);
            check_eq("rst_mono_dac", m_dac, 0);
        end else begin
            fs_e = 0; uf_e = 0;
            rel_cyc++;
            if (audio_mclk && !prev_mclk) begin
                rises++;
                if (rises % 4 == 0) begin
                    events++;
                    pos = int'(events % 64);
                    if (pos == 0) begin
                        fs_e = 1;
                        if (q.size() > 0) cur = q.pop_front();
                        else begin cur = '0; uf_e = 1; end
                    end
                    exp_lrck  = (pos >= 32);
                    exp_dac   = slot_bit((pos >= 32) ? cur.r : cur.l, pos % 32);
                    exp_dac_m = slot_bit(cur.l, pos % 32);
                end
            end
            prev_mclk = audio_mclk;
            if (push_ok) begin
                q.push_back(head);
                pend.delete(0);
            end
            check_eq("lrck", audio_lrck, exp_lrck);
            check_eq("dac", audio_dac, exp_dac);
            check_eq("mono_dac", m_dac, exp_dac_m);
            check_eq("frame_start", frame_start, fs_e);
            check_eq("underflow", underflow, uf_e);
            if (audio_lrck && !prev_lrck) begin
                if (lrck_last >= 0)
                    check_eq("lrck_period_in_1546_1548",
                             ((cyc - lrck_last) >= 1546) && ((cyc - lrck_last) <= 1548), 1);
                lrck_last = cyc;
            end
            prev_lrck = audio_lrck;
            if (rel_cyc == 40000) begin
                longint diff;
                diff = 2 * MOD * rises - longint'(rel_cyc) * INC;
                if (diff < 0) diff = -diff;
                check_eq("mclk_rises_within_1", diff <= 2 * MOD, 1);
            end
        end
        check_eq("ready", sample_ready, !reset && (q.size() < DEPTH));
        check_eq("mono_ready", m_ready, !reset && (q.size() < DEPTH));
    endtask

    function automatic pair_s rnd_pair();
        pair_s p;
        p.l = W'($urandom);
        p.r = W'($urandom);
        return p;
    endfunction

    initial begin
        pair_s p;
        int    found;
        // Reset held 10 cycles, FIFO empty
        reset = 1'b1;
        repeat (10) tick();
        reset = 1'b0;
        uf_seen = 0;
        repeat (1700) tick();
        check_eq("first_frame_underflow_count", uf_seen, 1);

        // Directed pairs, then enough to overfill a depth-4 FIFO
        p.l = 16'hA5C3; p.r = 16'h1234; pend.push_back(p);
        p.l = 16'h8001; p.r = 16'hFFFF; pend.push_back(p);
        repeat (3) pend.push_back(rnd_pair());
        offer = 1'b1;
        uf_seen = 0;
        repeat (4 * 1547 - 400) tick();
        if (DEPTH > 1) check_eq("fill_no_underflow", uf_seen, 0);
        repeat (4 * 1547 + 400) tick();
        check_eq("directed_all_accepted", pend.size(), 0);

        // Randomised traffic: sparse pushes give a mix of plays and underflows
        for (int i = 0; i < 60000 && rel_cyc < 40100; i++) begin
            if ($urandom_range(0, 1199) == 0) pend.push_back(rnd_pair());
            offer = ($urandom_range(0, 7) != 0);
            tick();
        end

        // Reset asserted mid-word in a right slot with data queued
        offer = 1'b1;
        repeat (2) pend.push_back(rnd_pair());
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            found = ((events % 64) >= 40) && ((events % 64) <= 50) && (q.size() > 0) ? 1 : 0;
        end
        check_eq("reached_right_slot", found, 1);
        pend.delete();
        offer = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        uf_seen = 0;
        repeat (1700) tick();
        check_eq("post_reset_underflow_count", uf_seen, 1);

        // Short randomised tail
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 999) == 0) pend.push_back(rnd_pair());
            offer = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
